mul_ext_ctrl: RTL and testbench

Sequencing and sign-handling front end for the RV32M multiply ops (MUL, MULH, MULHSU, MULHU) in the execute stage. Accepts an op from the pipeline and converts signed operands to magnitudes. Drives an external unsigned 32x32 shift-add multiplier core through its reset/finish contract, then sign-corrects and selects the 64-bit product. Returns one 32-bit result on a valid/ready response channel.

---
 rtl/mul_pkg.sv | 37 +++
 rtl/mul_sign_fix.sv | 17 +
 rtl/mul_ext_ctrl.sv | 130 +++++++++++++
 tb/tb_mul_ext_ctrl.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mul_pkg.sv
// Shared op encodings, controller state type and operand-signedness helpers
// for the RV32M multiply front end.
package mul_pkg;

  localparam logic [1:0] MUL_OP_MUL    = 2'b00;
  localparam logic [1:0] MUL_OP_MULH   = 2'b01;
  localparam logic [1:0] MUL_OP_MULHSU = 2'b10;
  localparam logic [1:0] MUL_OP_MULHU  = 2'b11;

  typedef enum logic [2:0] {
    StIdle,
    StLaunch,
    StArm,
    StWait,
    StDone
  } mul_ctrl_state_t;

  function automatic logic op_a_signed(logic [1:0] op);
    return (op == MUL_OP_MULH) || (op == MUL_OP_MULHSU);
  endfunction

  function automatic logic op_b_signed(logic [1:0] op);
    return (op == MUL_OP_MULH);
  endfunction

  // Result sign: MUL is sign-agnostic in its low word, so it never negates.
  function automatic logic op_result_neg(logic [1:0] op, logic a_msb, logic b_msb);
    logic neg;
    unique case (op)
      MUL_OP_MULH:   neg = a_msb ^ b_msb;
      MUL_OP_MULHSU: neg = a_msb;
      default:       neg = 1'b0;
    endcase
    return neg;
  endfunction

endpackage

// File: rtl/mul_sign_fix.sv
// Conditional 64-bit two's-complement negate followed by a hi/lo word select.
// With the upper half tied to zero and lo selected it yields a 32-bit magnitude.
module mul_sign_fix (
  input  logic [63:0] data,
  input  logic        neg,
  input  logic        sel_hi,
  output logic [31:0] res
);

  logic [63:0] fixed;

  always_comb begin
    fixed = neg ? (~data + 64'd1) : data;
    res   = sel_hi ? fixed[63:32] : fixed[31:0];
  end

endmodule

// File: rtl/mul_ext_ctrl.sv
// Execute-stage sequencer for MUL/MULH/MULHSU/MULHU around an external unsigned
// 32x32 shift-add core: operand magnitudes in, sign-corrected word out.
module mul_ext_ctrl
  import mul_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [1:0]  req_op,
  input  logic [31:0] req_a,
  input  logic [31:0] req_b,
  input  logic        flush,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_data,
  output logic        core_reset,
  output logic [31:0] core_a,
  output logic [31:0] core_b,
  input  logic [31:0] core_hi,
  input  logic [31:0] core_lo,
  input  logic        core_finish
);

  mul_ctrl_state_t state_q, state_d;
  logic [1:0]      op_q, op_d;
  logic            neg_q, neg_d;
  logic [31:0]     core_a_q, core_a_d;
  logic [31:0]     core_b_q, core_b_d;
  logic [31:0]     rsp_data_q, rsp_data_d;

  logic [31:0] mag_a, mag_b, result;
  logic        a_neg, b_neg, req_zero;

  assign a_neg    = op_a_signed(req_op) & req_a[31];
  assign b_neg    = op_b_signed(req_op) & req_b[31];
  assign req_zero = (req_a == 32'd0) || (req_b == 32'd0);

  mul_sign_fix u_mag_a (
    .data   ({32'd0, req_a}),
    .neg    (a_neg),
    .sel_hi (1'b0),
    .res    (mag_a)
  );

  mul_sign_fix u_mag_b (
    .data   ({32'd0, req_b}),
    .neg    (b_neg),
    .sel_hi (1'b0),
    .res    (mag_b)
  );

  mul_sign_fix u_result (
    .data   ({core_hi, core_lo}),
    .neg    (neg_q),
    .sel_hi (op_q != MUL_OP_MUL),
    .res    (result)
  );

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    neg_d      = neg_q;
    core_a_d   = core_a_q;
    core_b_d   = core_b_q;
    rsp_data_d = rsp_data_q;

    // Flush wins over acceptance, core_finish and rsp_ready alike.
    if (flush) begin
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (req_valid) begin
            op_d     = req_op;
            neg_d    = op_result_neg(req_op, req_a[31], req_b[31]);
            core_a_d = mag_a;
            core_b_d = mag_b;
            if (req_zero) begin
              rsp_data_d = 32'd0;
              state_d    = StDone;
            end else begin
              state_d = StLaunch;
            end
          end
        end
        StLaunch: state_d = StArm;
        // Blanking cycle: a stale finish from before the restart is not trusted.
        StArm:    state_d = StWait;
        StWait: begin
          if (core_finish) begin
            rsp_data_d = result;
            state_d    = StDone;
          end
        end
        StDone: begin
          if (rsp_ready) state_d = StIdle;
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= StIdle;
      op_q       <= MUL_OP_MUL;
      neg_q      <= 1'b0;
      core_a_q   <= 32'd0;
      core_b_q   <= 32'd0;
      rsp_data_q <= 32'd0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      neg_q      <= neg_d;
      core_a_q   <= core_a_d;
      core_b_q   <= core_b_d;
      rsp_data_q <= rsp_data_d;
    end
  end

  assign req_ready  = (state_q == StIdle);
  assign rsp_valid  = (state_q == StDone);
  assign rsp_data   = rsp_data_q;
  assign core_a     = core_a_q;
  assign core_b     = core_b_q;
  // Core runs only in ARM/WAIT; parked everywhere else, including reset.
  assign core_reset = !((state_q == StArm) || (state_q == StWait));

endmodule

// File: tb/tb_mul_ext_ctrl.sv
// Self-checking bench: directed table, random ops against an arithmetic model,
// and hand-written flush/reset/backpressure sequences with a modelled core.
module tb_mul_ext_ctrl;
  import mul_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        req_valid, req_ready;
  logic [1:0]  req_op;
  logic [31:0] req_a, req_b;
  logic        flush;
  logic        rsp_valid, rsp_ready;
  logic [31:0] rsp_data;
  logic        core_reset;
  logic [31:0] core_a, core_b;
  logic [31:0] core_hi = 32'd0;
  logic [31:0] core_lo = 32'd0;
  logic        core_finish = 1'b0;

  int errors = 0;
  int checks = 0;
  int rel_cnt = 0;

  always #5 clk = ~clk;

  mul_ext_ctrl dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_op      (req_op),
    .req_a       (req_a),
    .req_b       (req_b),
    .flush       (flush),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_data    (rsp_data),
    .core_reset  (core_reset),
    .core_a      (core_a),
    .core_b      (core_b),
    .core_hi     (core_hi),
    .core_lo     (core_lo),
    .core_finish (core_finish)
  );

  // External core: loads while held in reset, finishes 33 free-running edges later.
  logic [31:0] ca = 32'd0, cb = 32'd0;
  int          ccnt = 0;
  always @(posedge clk) begin
    if (core_reset) begin
      ca          <= core_a;
      cb          <= core_b;
      ccnt        <= 0;
      core_finish <= 1'b0;
    end else if (ccnt < 33) begin
      ccnt <= ccnt + 1;
      if (ccnt == 32) begin
        core_finish         <= 1'b1;
        {core_hi, core_lo}  <= {32'd0, ca} * {32'd0, cb};
      end
    end
  end

  always @(posedge clk) if (!core_reset) rel_cnt <= rel_cnt + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] ref_mul(logic [1:0] op, logic [31:0] a, logic [31:0] b);
    longint sa, sb, ua, ub;
    logic [63:0] p;
    sa = $signed(a);
    sb = $signed(b);
    ua = {32'd0, a};
    ub = {32'd0, b};
    case (op)
      MUL_OP_MULH:   p = sa * sb;
      MUL_OP_MULHSU: p = sa * ub;
      default:       p = ua * ub;
    endcase
    return (op == MUL_OP_MUL) ? p[31:0] : p[63:32];
  endfunction

  function automatic logic [31:0] mag(logic is_signed, logic [31:0] v);
    return (is_signed && v[31]) ? 32'(-v) : v;
  endfunction

  task automatic accept(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic rdy);
    @(negedge clk);
    req_valid = 1'b1;
    req_op    = op;
    req_a     = a;
    req_b     = b;
    rsp_ready = rdy;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
  endtask

  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp, input string tag);
    int k;
    int rel0;
    int exp_k;
    exp_k = (a == 0 || b == 0) ? 0 : 35;
    rel0  = rel_cnt;
    check({tag, "/ready"}, req_ready, 1'b1);
    accept(op, a, b, 1'b1);
    check({tag, "/core_a"}, core_a,
          mag((op == MUL_OP_MULH) || (op == MUL_OP_MULHSU), a));
    check({tag, "/core_b"}, core_b, mag(op == MUL_OP_MULH, b));
    k = 0;
    while (!rsp_valid && k < 100) begin
      @(posedge clk);
      #1;
      k++;
    end
    check({tag, "/valid_edge"}, k, exp_k);
    check({tag, "/data"}, rsp_data, exp);
    if (exp_k == 0) check({tag, "/core_released"}, rel_cnt - rel0, 0);
    @(posedge clk);
    #1;
    check({tag, "/idle_after_hs"}, {req_ready, rsp_valid}, 2'b10);
  endtask

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[7];

  initial begin
    logic [31:0] snap;
    logic        ok;
    int          k;

    vecs[0] = '{MUL_OP_MUL,    32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFEB};
    vecs[1] = '{MUL_OP_MULH,   32'h8000_0000, 32'h8000_0000, 32'h4000_0000};
    vecs[2] = '{MUL_OP_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE};
    vecs[3] = '{MUL_OP_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    vecs[4] = '{MUL_OP_MULH,   32'hFFFF_FFFF, 32'h0000_0001, 32'hFFFF_FFFF};
    vecs[5] = '{MUL_OP_MUL,    32'h0000_0000, 32'h0000_1234, 32'h0000_0000};
    vecs[6] = '{MUL_OP_MULHU,  32'h0000_1234, 32'h0000_0000, 32'h0000_0000};

    reset_n = 1'b0;
    req_valid = 1'b0;
    req_op = 2'b00;
    req_a = 32'd0;
    req_b = 32'd0;
    flush = 1'b0;
    rsp_ready = 1'b1;
    #1;
    check("reset/outputs", {rsp_valid, rsp_data, core_a, core_b, req_ready, core_reset},
          {1'b0, 32'd0, 32'd0, 32'd0, 1'b1, 1'b1});
    repeat (2) @(negedge clk);
    reset_n = 1'b1;

    for (int i = 0; i < 7; i++)
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp, $sformatf("vec%0d", i));

    for (int i = 0; i < 30; i++) begin
      logic [1:0]  op;
      logic [31:0] a, b;
      op = 2'($urandom_range(0, 3));
      a  = $urandom;
      b  = $urandom;
      case ($urandom_range(0, 7))
        0: a = 32'h8000_0000;
        1: b = 32'h8000_0000;
        2: a = 32'd0;
        3: b = 32'hFFFF_FFFF;
        default: ;
      endcase
      run_op(op, a, b, ref_mul(op, a, b), $sformatf("rnd%0d", i));
    end

    // Backpressure: DONE holds, data stable, core parked.
    accept(MUL_OP_MULH, 32'hDEAD_BEEF, 32'h1234_5678, 1'b0);
    k = 0;
    while (!rsp_valid && k < 100) begin
      @(posedge clk);
      #1;
      k++;
    end
    check("hold/valid_edge", k, 35);
    snap = rsp_data;
    check("hold/data", snap, ref_mul(MUL_OP_MULH, 32'hDEAD_BEEF, 32'h1234_5678));
    ok = 1'b1;
    repeat (10) begin
      @(posedge clk);
      #1;
      if (!rsp_valid || rsp_data !== snap || !core_reset || req_ready) ok = 1'b0;
    end
    check("hold/stable", ok, 1'b1);
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    check("hold/release", {req_ready, rsp_valid}, 2'b10);

    // Flush in WAIT with rsp_ready low: no response ever appears.
    accept(MUL_OP_MULHU, 32'hFFFF_FFFF, 32'h0000_0003, 1'b0);
    repeat (10) @(posedge clk);
    @(negedge clk);
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    check("flush_wait/ready", {req_ready, rsp_valid}, 2'b10);
    ok = 1'b1;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (rsp_valid) ok = 1'b0;
    end
    check("flush_wait/no_rsp", ok, 1'b1);
    run_op(MUL_OP_MUL, 32'd3, 32'd5, 32'd15, "after_flush");

    // Flush on the very edge the core finish would be captured.
    accept(MUL_OP_MUL, 32'd9, 32'd9, 1'b1);
    repeat (34) @(posedge clk);
    #1;
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    check("flush_finish/no_rsp", {req_ready, rsp_valid}, 2'b10);

    // Flush in IDLE suppresses acceptance.
    @(negedge clk);
    req_valid = 1'b1;
    req_op = MUL_OP_MUL;
    req_a = 32'd2;
    req_b = 32'd2;
    flush = 1'b1;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    flush = 1'b0;
    check("flush_idle/not_accepted", {req_ready, core_reset}, 2'b11);

    // Asynchronous reset mid-WAIT.
    accept(MUL_OP_MULH, 32'h8000_0001, 32'h7FFF_FFFF, 1'b1);
    repeat (10) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    check("rst_mid/outputs", {rsp_valid, rsp_data, core_a, core_b, req_ready, core_reset},
          {1'b0, 32'd0, 32'd0, 32'd0, 1'b1, 1'b1});
    @(posedge clk);
    #1;
    check("rst_mid/held", {rsp_valid, core_reset, req_ready}, 3'b011);
    @(negedge clk);
    reset_n = 1'b1;
    run_op(MUL_OP_MULH, 32'h8000_0001, 32'h7FFF_FFFF,
           ref_mul(MUL_OP_MULH, 32'h8000_0001, 32'h7FFF_FFFF), "after_rst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
